// File: rtl/vga_scan_engine_if.sv
// Pin-level bundle between the VGA scan engine, its framebuffer read port and the DAC.
// master = scan engine, slave = memory/DAC side.
interface vga_scan_engine_if;
    logic [31:0] datain;
    logic [31:0] dir;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic        o_hs;
    logic        o_vs;
    logic        o_blank;
    logic        o_sync;
    logic        o_clk;
    logic        frame_start;

    modport master (
        input  datain,
        output dir, r, g, b, o_hs, o_vs, o_blank, o_sync, o_clk, frame_start
    );

    modport slave (
        output datain,
        input  dir, r, g, b, o_hs, o_vs, o_blank, o_sync, o_clk, frame_start
    );
endinterface

// File: rtl/vga_scan_engine.sv
// VGA scan engine: pixel-tick divider, h/v fetch counters, linear framebuffer address and
// a MEM_LAT-tick alignment pipe so sync/blank land on the pins together with returned pixel data.
module vga_scan_engine #(
    parameter int          HACTIVE = 640,
    parameter int          HFP     = 16,
    parameter int          HSYN    = 96,
    parameter int          HBP     = 48,
    parameter int          VACTIVE = 480,
    parameter int          VFP     = 10,
    parameter int          VSYN    = 2,
    parameter int          VBP     = 33,
    parameter int          DIV     = 2,
    parameter int          MEM_LAT = 1,
    parameter bit          HS_POL  = 1'b0,
    parameter bit          VS_POL  = 1'b0,
    parameter logic [31:0] BASE    = 32'h0
) (
    input  logic             clk,
    input  logic             rst,
    vga_scan_engine_if.master vga
);

    localparam int HSS  = HSYN + HBP;
    localparam int HSE  = HSS + HACTIVE;
    localparam int HMAX = HSE + HFP;
    localparam int VSS  = VSYN + VBP;
    localparam int VSE  = VSS + VACTIVE;
    localparam int VMAX = VSE + VFP;

    localparam int HW = $clog2(HMAX);
    localparam int VW = $clog2(VMAX);
    localparam int CW = $clog2(DIV);

    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2);
    localparam logic [HW-1:0] HX_LAST  = HW'(HMAX - 1);
    localparam logic [HW-1:0] HSYN_END = HW'(HSYN);
    localparam logic [HW-1:0] HSS_P    = HW'(HSS);
    localparam logic [HW-1:0] HSE_P    = HW'(HSE);
    localparam logic [VW-1:0] VY_LAST  = VW'(VMAX - 1);
    localparam logic [VW-1:0] VSYN_END = VW'(VSYN);
    localparam logic [VW-1:0] VSS_P    = VW'(VSS);
    localparam logic [VW-1:0] VSE_P    = VW'(VSE);

    logic [CW-1:0]      cnt;
    logic [CW-1:0]      cnt_nxt;
    logic               tick;
    logic               o_clk_q;
    logic [HW-1:0]      hx;
    logic [HW-1:0]      hx_nxt;
    logic [VW-1:0]      vy;
    logic [VW-1:0]      vy_nxt;
    logic               hs_r;
    logic               vs_r;
    logic               act_r;
    logic               act_pre;
    logic [31:0]        dir_q;
    logic               frame_start_q;
    logic [MEM_LAT-1:0] hs_sr;
    logic [MEM_LAT-1:0] vs_sr;
    logic [MEM_LAT-1:0] act_sr;
    logic [23:0]        rgb_q;
    logic               unused_hi;

    always_comb begin
        tick    = (cnt == CNT_LAST);
        cnt_nxt = tick ? '0 : cnt + 1'b1;
        hx_nxt  = (hx == HX_LAST) ? '0 : hx + 1'b1;
        vy_nxt  = vy;
        if (hx == HX_LAST) begin
            vy_nxt = (vy == VY_LAST) ? '0 : vy + 1'b1;
        end
        hs_r  = (hx < HSYN_END);
        vs_r  = (vy < VSYN_END);
        act_r = (hx >= HSS_P) && (hx < HSE_P) && (vy >= VSS_P) && (vy < VSE_P);
    end

    // o_clk is registered from the next count so its rising edge lands on the tick edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            o_clk_q <= 1'b0;
        end else begin
            cnt     <= cnt_nxt;
            o_clk_q <= (cnt_nxt < CNT_HALF);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hx            <= '0;
            vy            <= '0;
            dir_q         <= BASE;
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= tick && (hx == HX_LAST) && (vy == VY_LAST);
            if (tick) begin
                hx <= hx_nxt;
                vy <= vy_nxt;
                if ((hx_nxt == HSS_P) && (vy_nxt == VSS_P)) begin
                    dir_q <= BASE;
                end else if (act_r) begin
                    dir_q <= dir_q + 32'd1;
                end
            end
        end
    end

    // Colour is loaded one stage before the pipe tail so it leaves together with blank/syncs
    generate
        if (MEM_LAT == 1) begin : g_lat1
            assign act_pre = act_r;
        end else begin : g_latn
            assign act_pre = act_sr[MEM_LAT-2];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_sr  <= '0;
            vs_sr  <= '0;
            act_sr <= '0;
            rgb_q  <= '0;
        end else if (tick) begin
            hs_sr[0]  <= hs_r;
            vs_sr[0]  <= vs_r;
            act_sr[0] <= act_r;
            for (int i = 1; i < MEM_LAT; i++) begin
                hs_sr[i]  <= hs_sr[i-1];
                vs_sr[i]  <= vs_sr[i-1];
                act_sr[i] <= act_sr[i-1];
            end
            rgb_q <= act_pre ? vga.datain[23:0] : 24'h0;
        end
    end

    assign vga.o_hs        = hs_sr[MEM_LAT-1] ? HS_POL : ~HS_POL;
    assign vga.o_vs        = vs_sr[MEM_LAT-1] ? VS_POL : ~VS_POL;
    assign vga.o_blank     = act_sr[MEM_LAT-1];
    assign vga.r           = rgb_q[23:16];
    assign vga.g           = rgb_q[15:8];
    assign vga.b           = rgb_q[7:0];
    assign vga.o_sync      = 1'b0;
    assign vga.o_clk       = o_clk_q;
    assign vga.dir         = dir_q;
    assign vga.frame_start = frame_start_q;
    assign unused_hi       = ^vga.datain[31:24];

endmodule

// File: tb/tb_vga_scan_engine.sv
// Bench for vga_scan_engine: two small-timing instances (DIV=2/MEM_LAT=1/active-high syncs and
// DIV=4/MEM_LAT=3/active-low syncs) checked every clk against a frame-arithmetic reference model.
module tb_vga_scan_engine;

    localparam int          A_DIV = 2, A_LAT = 1;
    localparam int          A_HACT = 4, A_HFP = 1, A_HSYN = 1, A_HBP = 1;
    localparam int          A_VACT = 2, A_VFP = 1, A_VSYN = 1, A_VBP = 1;
    localparam bit          A_HPOL = 1'b1, A_VPOL = 1'b1;
    localparam logic [31:0] A_BASE = 32'h0000_1000;

    localparam int          B_DIV = 4, B_LAT = 3;
    localparam int          B_HACT = 6, B_HFP = 2, B_HSYN = 3, B_HBP = 2;
    localparam int          B_VACT = 3, B_VFP = 1, B_VSYN = 2, B_VBP = 1;
    localparam bit          B_HPOL = 1'b0, B_VPOL = 1'b0;
    localparam logic [31:0] B_BASE = 32'h00AB_C000;

    typedef struct {
        int          div, lat;
        int          hact, hfp, hsyn, hbp;
        int          vact, vfp, vsyn, vbp;
        bit          hpol, vpol;
        logic [31:0] base;
    } cfg_t;

    typedef struct {
        logic        hs, vs, blank, oclk, fs;
        logic [23:0] rgb;
        logic [31:0] dir;
    } pins_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] seed;
    cfg_t        ca, cb;
    logic [31:0] hist_a[$];
    logic [31:0] hist_b[$];

    always #5 clk = ~clk;

    vga_scan_engine_if ifa ();
    vga_scan_engine_if ifb ();

    vga_scan_engine #(
        .HACTIVE(A_HACT), .HFP(A_HFP), .HSYN(A_HSYN), .HBP(A_HBP),
        .VACTIVE(A_VACT), .VFP(A_VFP), .VSYN(A_VSYN), .VBP(A_VBP),
        .DIV(A_DIV), .MEM_LAT(A_LAT), .HS_POL(A_HPOL), .VS_POL(A_VPOL), .BASE(A_BASE)
    ) dut_a (
        .clk(clk),
        .rst(rst),
        .vga(ifa)
    );

    vga_scan_engine #(
        .HACTIVE(B_HACT), .HFP(B_HFP), .HSYN(B_HSYN), .HBP(B_HBP),
        .VACTIVE(B_VACT), .VFP(B_VFP), .VSYN(B_VSYN), .VBP(B_VBP),
        .DIV(B_DIV), .MEM_LAT(B_LAT), .HS_POL(B_HPOL), .VS_POL(B_VPOL), .BASE(B_BASE)
    ) dut_b (
        .clk(clk),
        .rst(rst),
        .vga(ifb)
    );

    function automatic logic [31:0] memval(input logic [31:0] s, input logic [31:0] addr);
        return (addr * 32'h9E37_79B1) ^ s;
    endfunction

    function automatic int clampi(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    // Expected pins e clk edges after reset release (e=0 means in/just out of reset)
    function automatic pins_t model(input cfg_t c, input int e, input logic [31:0] s);
        pins_t       p;
        int          hss, vss, hmax, vmax, fr, m, pos, hx, vy, n, k;
        bit          act;
        logic [31:0] word;
        hss  = c.hsyn + c.hbp;
        vss  = c.vsyn + c.vbp;
        hmax = hss + c.hact + c.hfp;
        vmax = vss + c.vact + c.vfp;
        fr   = hmax * vmax;
        m    = e / c.div;
        p.oclk = (e == 0) ? 1'b0 : ((e % c.div) < (c.div / 2));
        p.fs   = (e > 0) && ((e % c.div) == 0) && ((m % fr) == 0);

        pos = m % fr;
        hx  = pos % hmax;
        vy  = pos / hmax;
        n   = clampi(vy - vss, 0, c.vact) * c.hact;
        if (vy >= vss && vy < vss + c.vact) n += clampi(hx - hss, 0, c.hact);
        if (pos < vss * hmax + hss)
            p.dir = (m >= fr) ? c.base + 32'(c.hact * c.vact) : c.base;
        else
            p.dir = c.base + 32'(n);

        if (m < c.lat) begin
            p.hs    = ~c.hpol;
            p.vs    = ~c.vpol;
            p.blank = 1'b0;
            p.rgb   = 24'h0;
        end else begin
            k   = m - c.lat;
            pos = k % fr;
            hx  = pos % hmax;
            vy  = pos / hmax;
            act = (hx >= hss) && (hx < hss + c.hact) && (vy >= vss) && (vy < vss + c.vact);
            p.hs    = (hx < c.hsyn) ? c.hpol : ~c.hpol;
            p.vs    = (vy < c.vsyn) ? c.vpol : ~c.vpol;
            p.blank = act;
            word    = memval(s, c.base + 32'((vy - vss) * c.hact + (hx - hss)));
            p.rgb   = act ? word[23:0] : 24'h0;
        end
        return p;
    endfunction

    task automatic check_one(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_inst(input string nm, input cfg_t c, input int e,
                              input logic hs, input logic vs, input logic blank,
                              input logic oclk, input logic fs, input logic sync,
                              input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                              input logic [31:0] dir);
        pins_t p;
        p = model(c, e, seed);
        check_one($sformatf("%s.o_hs e=%0d", nm, e), 32'(hs), 32'(p.hs));
        check_one($sformatf("%s.o_vs e=%0d", nm, e), 32'(vs), 32'(p.vs));
        check_one($sformatf("%s.o_blank e=%0d", nm, e), 32'(blank), 32'(p.blank));
        check_one($sformatf("%s.o_clk e=%0d", nm, e), 32'(oclk), 32'(p.oclk));
        check_one($sformatf("%s.frame_start e=%0d", nm, e), 32'(fs), 32'(p.fs));
        check_one($sformatf("%s.o_sync e=%0d", nm, e), 32'(sync), 32'h0);
        check_one($sformatf("%s.rgb e=%0d", nm, e), {8'h0, r, g, b}, {8'h0, p.rgb});
        check_one($sformatf("%s.dir e=%0d", nm, e), dir, p.dir);
    endtask

    task automatic check_both(input int e);
        check_inst("A", ca, e, ifa.o_hs, ifa.o_vs, ifa.o_blank, ifa.o_clk, ifa.frame_start,
                   ifa.o_sync, ifa.r, ifa.g, ifa.b, ifa.dir);
        check_inst("B", cb, e, ifb.o_hs, ifb.o_vs, ifb.o_blank, ifb.o_clk, ifb.frame_start,
                   ifb.o_sync, ifb.r, ifb.g, ifb.b, ifb.dir);
    endtask

    // Framebuffer model: data for an address issued on dir shows up MEM_LAT-1 ticks later
    task automatic mem_step(input int e);
        if (e == 0) begin
            hist_a.delete();
            hist_b.delete();
            hist_a.push_front(ifa.dir);
            hist_b.push_front(ifb.dir);
        end else begin
            if ((e % A_DIV) == 0) hist_a.push_front(ifa.dir);
            if ((e % B_DIV) == 0) hist_b.push_front(ifb.dir);
        end
        while (hist_a.size() > 8) void'(hist_a.pop_back());
        while (hist_b.size() > 8) void'(hist_b.pop_back());
        ifa.datain = (hist_a.size() >= A_LAT) ? memval(seed, hist_a[A_LAT-1]) : 32'hFFFF_FFFF;
        ifb.datain = (hist_b.size() >= B_LAT) ? memval(seed, hist_b[B_LAT-1]) : 32'hFFFF_FFFF;
    endtask

    initial begin
        int e;
        int len;
        ca = '{div: A_DIV, lat: A_LAT, hact: A_HACT, hfp: A_HFP, hsyn: A_HSYN, hbp: A_HBP,
               vact: A_VACT, vfp: A_VFP, vsyn: A_VSYN, vbp: A_VBP,
               hpol: A_HPOL, vpol: A_VPOL, base: A_BASE};
        cb = '{div: B_DIV, lat: B_LAT, hact: B_HACT, hfp: B_HFP, hsyn: B_HSYN, hbp: B_HBP,
               vact: B_VACT, vfp: B_VFP, vsyn: B_VSYN, vbp: B_VBP,
               hpol: B_HPOL, vpol: B_VPOL, base: B_BASE};
        seed       = $urandom;
        ifa.datain = 32'h0;
        ifb.datain = 32'h0;

        #1 rst = 1'b1;
        #1 check_both(0);
        repeat (2) @(posedge clk);
        #1 check_both(0);

        for (int phase = 0; phase < 4; phase++) begin
            @(negedge clk);
            rst = 1'b0;
            e   = 0;
            mem_step(e);
            len = (phase == 0) ? 800 : int'($urandom_range(150, 1000));
            for (int i = 0; i < len; i++) begin
                @(posedge clk);
                #1;
                e++;
                check_both(e);
                mem_step(e);
            end
            // Asynchronous reset between clk edges: outputs must drop without a clock
            #($urandom_range(1, 3));
            rst = 1'b1;
            #1 check_both(0);
            repeat (3) @(posedge clk);
            #1 check_both(0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
